// File: rtl/modn_seq_pkg.sv
// modn_seq_pkg: shared types and constants for the modulo-N run sequencer.
//   seq_state_e : run-controller states
//   MOD_MIN     : smallest modulus a start is allowed to program
package modn_seq_pkg;
    typedef enum logic [1:0] {IDLE, RUN, PAUSE} seq_state_e;
    localparam int MOD_MIN = 2;
endpackage

// File: rtl/modn_sequencer_if.sv
// modn_sequencer_if: config/command strobes and status outputs of the sequencer.
//   master : cfg_mod, cfg_periods, start, stop, pause out; cnt, busy, wrap, done,
//            periods_left, cfg_err in
//   slave  : the sequencer side, directions mirrored
interface modn_sequencer_if #(
    parameter int W  = 10,
    parameter int PW = 8
);
    logic [W-1:0]  cfg_mod;
    logic [PW-1:0] cfg_periods;
    logic          start;
    logic          stop;
    logic          pause;
    logic [W-1:0]  cnt;
    logic          busy;
    logic          wrap;
    logic          done;
    logic [PW-1:0] periods_left;
    logic          cfg_err;

    modport master (
        output cfg_mod, cfg_periods, start, stop, pause,
        input  cnt, busy, wrap, done, periods_left, cfg_err
    );

    modport slave (
        input  cfg_mod, cfg_periods, start, stop, pause,
        output cnt, busy, wrap, done, periods_left, cfg_err
    );
endinterface

// File: rtl/modn_count_core.sv
// modn_count_core: W-bit counter with enable, sync clear and runtime-modulus compare.
//   clk, rst  : clock, async active-high reset
//   en_i      : increment on this edge
//   clr_i     : clear to 0 on this edge (wins over en_i)
//   mod_i     : current modulus M
//   cnt_o     : registered count
//   at_max_o  : combinational, high when cnt_o == M-1
module modn_count_core #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en_i,
    input  logic         clr_i,
    input  logic [W-1:0] mod_i,
    output logic [W-1:0] cnt_o,
    output logic         at_max_o
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb cnt_d = clr_i ? '0 : en_i ? cnt_q + W'(1) : cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign cnt_o    = cnt_q;
    assign at_max_o = cnt_q == mod_i - W'(1);
endmodule

// File: rtl/modn_sequencer.sv
// modn_sequencer: IDLE/RUN/PAUSE run controller for a modulo-N counter.
//   clk, rst : clock, async active-high reset
//   bus      : slave side of modn_sequencer_if
//              in : cfg_mod, cfg_periods, start, stop, pause
//              out: cnt, busy, wrap, done, periods_left, cfg_err (all registered)
module modn_sequencer
    import modn_seq_pkg::*;
#(
    parameter int W  = 10,
    parameter int PW = 8
) (
    input  logic              clk,
    input  logic              rst,
    modn_sequencer_if.slave   bus
);
    seq_state_e    state_q, state_d;
    logic [W-1:0]  mod_q, mod_d;
    logic [PW-1:0] periods_left_q, periods_left_d;
    logic          wrap_q, wrap_d;
    logic          done_q, done_d;
    logic          cfg_err_q, cfg_err_d;
    logic          cnt_en, cnt_clr, at_max;

    modn_count_core #(.W(W)) u_core (
        .clk      (clk),
        .rst      (rst),
        .en_i     (cnt_en),
        .clr_i    (cnt_clr),
        .mod_i    (mod_q),
        .cnt_o    (bus.cnt),
        .at_max_o (at_max)
    );

    // A busy sequencer treats RUN and PAUSE alike: pause low means this edge
    // counts, so leaving PAUSE costs no extra cycle beyond the paused ones.
    always_comb begin
        state_d        = state_q;
        mod_d          = mod_q;
        periods_left_d = periods_left_q;
        wrap_d         = 1'b0;
        done_d         = 1'b0;
        cfg_err_d      = 1'b0;
        cnt_en         = 1'b0;
        cnt_clr        = 1'b0;
        if (bus.stop) begin
            state_d        = IDLE;
            periods_left_d = '0;
            cnt_clr        = 1'b1;
        end else if (state_q == IDLE) begin
            if (bus.start && bus.cfg_mod < W'(MOD_MIN)) begin
                cfg_err_d = 1'b1;
            end else if (bus.start) begin
                state_d        = RUN;
                mod_d          = bus.cfg_mod;
                periods_left_d = bus.cfg_periods;
                cnt_clr        = 1'b1;
            end
        end else if (bus.pause) begin
            state_d = PAUSE;
        end else if (at_max) begin
            state_d = RUN;
            cnt_clr = 1'b1;
            wrap_d  = 1'b1;
            // periods_left of 0 means free-run: never decremented, never done
            if (periods_left_q == PW'(1)) begin
                done_d         = 1'b1;
                periods_left_d = '0;
                state_d        = IDLE;
            end else if (periods_left_q != '0) begin
                periods_left_d = periods_left_q - PW'(1);
            end
        end else begin
            state_d = RUN;
            cnt_en  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            mod_q          <= '0;
            periods_left_q <= '0;
            wrap_q         <= 1'b0;
            done_q         <= 1'b0;
            cfg_err_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            mod_q          <= mod_d;
            periods_left_q <= periods_left_d;
            wrap_q         <= wrap_d;
            done_q         <= done_d;
            cfg_err_q      <= cfg_err_d;
        end
    end

    assign bus.busy         = state_q != IDLE;
    assign bus.wrap         = wrap_q;
    assign bus.done         = done_q;
    assign bus.cfg_err      = cfg_err_q;
    assign bus.periods_left = periods_left_q;
endmodule

// File: tb/tb_modn_sequencer.sv
// tb_modn_sequencer: directed + randomized bench with a tick-counting reference model.
module tb_modn_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    // reference model: a run is "ticks elapsed since start"; count and wraps
    // follow from ticks by division and remainder
    bit m_busy  = 1'b0;
    int m_ticks = 0;
    int m_mod   = 0;
    int m_p     = 0;
    bit wrap_e  = 1'b0;
    bit done_e  = 1'b0;
    bit err_e   = 1'b0;

    modn_sequencer_if #(.W(10), .PW(8)) bus ();

    modn_sequencer #(.W(10), .PW(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.start       = 1'b0;
        bus.stop        = 1'b0;
        bus.pause       = 1'b0;
        bus.cfg_mod     = '0;
        bus.cfg_periods = '0;
    endtask

    task automatic check_all_zero(input string nm);
        chk({nm, "_cnt"}, bus.cnt, 0);
        chk({nm, "_busy"}, bus.busy, 0);
        chk({nm, "_wrap"}, bus.wrap, 0);
        chk({nm, "_done"}, bus.done, 0);
        chk({nm, "_pl"}, bus.periods_left, 0);
        chk({nm, "_err"}, bus.cfg_err, 0);
    endtask

    task automatic async_reset(input string nm);
        #2 rst = 1'b1;
        #1 check_all_zero(nm);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic start_run(input int m, input int p);
        bus.cfg_mod     = 10'(m);
        bus.cfg_periods = 8'(p);
        bus.start       = 1'b1;
        step(1);
        bus.start       = 1'b0;
    endtask

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            wrap_e = 1'b0;
            done_e = 1'b0;
            err_e  = 1'b0;
            if (rst) begin
                m_busy = 1'b0; m_ticks = 0; m_mod = 0; m_p = 0;
            end else if (bus.stop) begin
                m_busy = 1'b0; m_ticks = 0;
            end else if (!m_busy) begin
                if (bus.start && bus.cfg_mod < 2) err_e = 1'b1;
                else if (bus.start) begin
                    m_busy = 1'b1; m_ticks = 0;
                    m_mod = int'(bus.cfg_mod); m_p = int'(bus.cfg_periods);
                end
            end else if (!bus.pause) begin
                m_ticks++;
                if (m_ticks % m_mod == 0) begin
                    wrap_e = 1'b1;
                    if (m_p != 0 && m_ticks / m_mod == m_p) begin
                        done_e = 1'b1;
                        m_busy = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            chk("cnt", bus.cnt, m_busy ? m_ticks % m_mod : 0);
            chk("busy", bus.busy, m_busy);
            chk("wrap", bus.wrap, wrap_e);
            chk("done", bus.done, done_e);
            chk("periods_left", bus.periods_left,
                (!m_busy || m_p == 0) ? 0 : m_p - m_ticks / m_mod);
            chk("cfg_err", bus.cfg_err, err_e);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: timeout reached, expected bench to finish");
        $fatal(1, "timeout");
    end

    initial begin
        int nw, nd;
        idle_inputs();
        step(3);
        rst = 1'b0;
        check_all_zero("reset");

        // counted run M=10 P=2
        step(1);
        start_run(10, 2);
        chk("run_start_cnt", bus.cnt, 0);
        chk("run_start_busy", bus.busy, 1);
        chk("run_start_pl", bus.periods_left, 2);
        step(9);
        chk("run_k9_cnt", bus.cnt, 9);
        chk("run_k9_wrap", bus.wrap, 0);
        step(1);
        chk("run_k10_cnt", bus.cnt, 0);
        chk("run_k10_wrap", bus.wrap, 1);
        chk("run_k10_pl", bus.periods_left, 1);
        chk("run_k10_done", bus.done, 0);
        step(9);
        chk("run_k19_cnt", bus.cnt, 9);
        step(1);
        chk("run_k20_wrap", bus.wrap, 1);
        chk("run_k20_done", bus.done, 1);
        chk("run_k20_busy", bus.busy, 0);
        chk("run_k20_pl", bus.periods_left, 0);
        step(1);
        chk("run_k21_done", bus.done, 0);

        // pause 3 cycles at cnt=3, M=5 P=1
        start_run(5, 1);
        step(3);
        chk("pause_pre_cnt", bus.cnt, 3);
        bus.pause = 1'b1;
        step(3);
        chk("pause_hold_cnt", bus.cnt, 3);
        chk("pause_hold_busy", bus.busy, 1);
        bus.pause = 1'b0;
        step(1);
        chk("pause_k7_cnt", bus.cnt, 4);
        chk("pause_k7_wrap", bus.wrap, 0);
        step(1);
        chk("pause_k8_wrap", bus.wrap, 1);
        chk("pause_k8_done", bus.done, 1);
        chk("pause_k8_busy", bus.busy, 0);

        // stop at cnt=7 with start also high
        start_run(10, 3);
        step(7);
        chk("stop_pre_cnt", bus.cnt, 7);
        bus.stop  = 1'b1;
        bus.start = 1'b1;
        step(1);
        chk("stop_busy", bus.busy, 0);
        chk("stop_cnt", bus.cnt, 0);
        chk("stop_wrap", bus.wrap, 0);
        chk("stop_done", bus.done, 0);
        step(2);
        chk("stop_held_busy", bus.busy, 0);
        bus.start = 1'b0;
        step(1);
        bus.stop = 1'b0;
        step(2);
        chk("stop_norestart_busy", bus.busy, 0);

        // bad modulus 1 and 0
        for (int m = 1; m >= 0; m--) begin
            start_run(m, 2);
            chk("badmod_err", bus.cfg_err, 1);
            chk("badmod_busy", bus.busy, 0);
            step(1);
            chk("badmod_err_clr", bus.cfg_err, 0);
        end

        // boundary M=2 starts accepted
        start_run(2, 1);
        chk("mod2_busy", bus.busy, 1);
        step(2);
        chk("mod2_done", bus.done, 1);

        // free-run M=4 with config change and start while busy
        start_run(4, 0);
        nw = 0; nd = 0;
        for (int i = 0; i < 40; i++) begin
            if (i == 10) begin
                bus.cfg_mod = 10'd6; bus.cfg_periods = 8'd1; bus.start = 1'b1;
            end
            if (i == 12) bus.start = 1'b0;
            step(1);
            nw += int'(bus.wrap);
            nd += int'(bus.done);
        end
        chk("free_wraps", nw, 10);
        chk("free_dones", nd, 0);
        chk("free_pl", bus.periods_left, 0);
        chk("free_busy", bus.busy, 1);

        // reset mid-run
        async_reset("midrun");
        chk("midrun_after_busy", bus.busy, 0);

        // randomized phase
        idle_inputs();
        for (int i = 0; i < 4000; i++) begin
            bus.stop        = ($urandom_range(0, 59) == 0);
            bus.pause       = ($urandom_range(0, 7) == 0);
            bus.start       = ($urandom_range(0, 3) == 0);
            bus.cfg_mod     = ($urandom_range(0, 9) == 0) ? 10'($urandom_range(0, 1))
                                                          : 10'($urandom_range(2, 9));
            bus.cfg_periods = 8'($urandom_range(0, 3));
            if ($urandom_range(0, 499) == 0) async_reset("rand_rst");
            else step(1);
        end

        idle_inputs();
        step(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/modn_sequencer.md
# modn_sequencer

Run controller for the modulo-N counter datapath. It latches a runtime modulus and a period count, then sequences the counter through IDLE, RUN and PAUSE. It emits a wrap pulse each time the count rolls over and a done pulse after the programmed number of periods. It sits between software-visible config/command strobes and the counter core, and owns all start/stop/pause decisions.

## Interface
- `W`, 10: counter width; legal moduli are 2..2^W-1.
- `PW`, 8: period-count width.
- `clk` in 1: single clock; all state changes on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `cfg_mod` in W: modulus M, sampled only on an accepted start.
- `cfg_periods` in PW: number of wraps before done; 0 = free-run.
- `start` in 1: level sampled each edge; honoured only in IDLE.
- `stop` in 1: abort from any state; highest priority.
- `pause` in 1: level; holds the count while high.
- `cnt` out W: current count, registered.
- `busy` out 1: high in RUN or PAUSE.
- `wrap` out 1: one-cycle pulse on rollover.
- `done` out 1: one-cycle pulse on the final rollover.
- `periods_left` out PW: remaining wraps; 0 in free-run.
- `cfg_err` out 1: one-cycle pulse when start is rejected.

## Operation
- States: IDLE, RUN, PAUSE.
- **Reset values:** IDLE, cnt=0, busy=0, wrap=0, done=0, periods_left=0, cfg_err=0, latched mod=0.
- **IDLE, start=1, stop=0:**
  - If cfg_mod<2: pulse cfg_err and stay in IDLE.
  - Otherwise: latch mod_q=cfg_mod and periods_left=cfg_periods, set cnt=0, go to RUN.
- **RUN:**
  - If cnt==mod_q-1: cnt←0 and pulse wrap. Otherwise cnt←cnt+1.
  - On wrap with periods_left==1: pulse done, set periods_left←0, go to IDLE (cnt=0).
  - On wrap with periods_left>1: decrement periods_left.
  - In free-run (periods_left==0): never decrement, never done.
- **RUN, pause=1:** go to PAUSE. cnt and periods_left hold, and no increment happens on that edge.
- **PAUSE:** hold everything. When pause=0, return to RUN; counting resumes on the following edge.
- **stop=1 in any state:** go to IDLE, cnt=0, periods_left=0. No wrap, no done. Wins over start, pause and rollover on the same edge.
- **start while busy:** ignored. cfg_mod and cfg_periods changes while busy are ignored.
- **Width rules:** compare cnt against mod_q-1 at W bits; counting never exceeds mod_q-1. periods_left decrements with no underflow (guarded at 0).
- **Pulses:** wrap, done and cfg_err are single-cycle and registered. done is always coincident with a wrap.
- **Reset mid-run:** asynchronous return to the reset values; no pulse is emitted.

## Timing
- Start accepted at edge k: busy=1, cnt=0 after k; cnt=1 after k+1.
- Rollover: wrap is high in the cycle where cnt reads 0 after mod_q-1. First wrap comes M edges after the start edge.
- Period count P: done is coincident with wrap after P·M edges from the start edge, and busy drops at that same edge.
- Each pause cycle extends the total by exactly one cycle.
- Start may be re-asserted the cycle after done; back-to-back runs then have no dead cycle beyond that one.
- cfg_err: asserted the cycle after the rejected start edge.

## Structure
- **Package `modn_seq_pkg`:**
  - `seq_state_e` enum {IDLE, RUN, PAUSE}.
  - Constant `MOD_MIN`=2.
- **Sub-module `modn_count_core`:** holds the W-bit register with enable, sync clear and a runtime-modulus compare. Outputs cnt and a combinational at_max.
- **`modn_sequencer`:** owns the FSM, the mod_q/periods_left registers and the pulse registers.

## Test plan
- **Reset:** assert rst mid-cycle → all outputs 0 immediately, state IDLE.
- **Counted run:** start with cfg_mod=10, cfg_periods=2 → cnt 0..9,0..9; wrap after edges 10 and 20; done and busy=0 after edge 20; periods_left goes 2→1→0.
- **Pause:** run with M=5, hold pause for 3 cycles at cnt=3 → cnt stays 3 for 3 cycles; wrap is delayed by exactly 3 cycles.
- **Stop:** stop at cnt=7 during a run with M=10, P=3, with start also high → IDLE, cnt=0, no wrap, no done, no restart.
- **Bad modulus:** start with cfg_mod=1 → cfg_err pulse, busy stays 0. Repeat with cfg_mod=0 → same result.
- **Free-run and change-while-busy:** start with M=4, P=0 → wrap every 4 cycles for 40 cycles, periods_left=0, no done. Changing cfg_mod to 6 mid-run has no effect.
